// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_muldiv_unit
// Description : EX-stage iterative multiply/divide unit with HI/LO registers.
//               Define MULDIV_SIGNED_EN for two's-complement MULT/DIV.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic        md_kill,
  output logic        md_busy,
  output logic        md_done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] c_OP_MULT  = 3'b001;
  localparam logic [2:0] c_OP_MULTU = 3'b010;
  localparam logic [2:0] c_OP_DIV   = 3'b011;
  localparam logic [2:0] c_OP_DIVU  = 3'b100;
  localparam logic [2:0] c_OP_MTHI  = 3'b101;
  localparam logic [2:0] c_OP_MTLO  = 3'b110;
  localparam logic [4:0] c_LAST_ITER = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc;
  logic [31:0] r_b;
  logic [31:0] r_opd;
  logic        r_is_div;

  logic        w_idle_ok;
  logic        w_is_md;
  logic        w_accept;
  logic        w_op_div;
  logic        w_mthi;
  logic        w_mtlo;
  logic        w_fix_write;
  logic [31:0] w_mag_a;
  logic [31:0] w_mag_b;

  assign w_idle_ok   = (r_state == S_IDLE) && ex_valid && !md_kill;
  assign w_is_md     = (ex_op == c_OP_MULT) || (ex_op == c_OP_MULTU) ||
                       (ex_op == c_OP_DIV)  || (ex_op == c_OP_DIVU);
  assign w_accept    = w_idle_ok && w_is_md;
  assign w_op_div    = (ex_op == c_OP_DIV) || (ex_op == c_OP_DIVU);
  assign w_mthi      = w_idle_ok && (ex_op == c_OP_MTHI);
  assign w_mtlo      = w_idle_ok && (ex_op == c_OP_MTLO);
  assign w_fix_write = (r_state == S_FIX) && !md_kill;

`ifdef MULDIV_SIGNED_EN
  logic w_signed_op;
  logic w_sa;
  logic w_sb;
  logic r_sa;
  logic r_sb;
  logic r_divz;

  assign w_signed_op = (ex_op == c_OP_MULT) || (ex_op == c_OP_DIV);
  assign w_sa        = w_signed_op && ex_rs_data[31];
  assign w_sb        = w_signed_op && ex_rt_data[31];
  assign w_mag_a     = w_sa ? (~ex_rs_data + 32'd1) : ex_rs_data;
  assign w_mag_b     = w_sb ? (~ex_rt_data + 32'd1) : ex_rt_data;

  // Divide-by-zero keeps the all-ones quotient, so LO must skip negation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sa   <= 1'b0;
      r_sb   <= 1'b0;
      r_divz <= 1'b0;
    end else if (w_accept) begin
      r_sa   <= w_sa;
      r_sb   <= w_sb;
      r_divz <= (ex_rt_data == 32'd0);
    end
  end
`else
  assign w_mag_a = ex_rs_data;
  assign w_mag_b = ex_rt_data;
`endif

  // Multiply step: conditional add, then shift {acc, multiplier} right.
  logic [32:0] w_msum;
  assign w_msum = {1'b0, r_acc} + (r_b[0] ? {1'b0, r_opd} : 33'd0);

  // Restoring divide step: shift dividend bit into remainder, trial subtract.
  logic [32:0] w_dshift;
  logic [33:0] w_ddiff;
  logic        w_qbit;
  assign w_dshift = {r_acc, r_b[31]};
  assign w_ddiff  = {1'b0, w_dshift} - {2'b00, r_opd};
  assign w_qbit   = ~w_ddiff[33];

  logic [63:0] w_prod;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  always_comb begin
    w_prod = {r_acc, r_b};
    w_quot = r_b;
    w_rem  = r_acc;
`ifdef MULDIV_SIGNED_EN
    if (r_sa ^ r_sb)
      w_prod = ~{r_acc, r_b} + 64'd1;
    if ((r_sa ^ r_sb) && !r_divz)
      w_quot = ~r_b + 32'd1;
    if (r_sa)
      w_rem = ~r_acc + 32'd1;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept)
          w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (md_kill)
          w_state_nxt = S_IDLE;
        else if (r_cnt == c_LAST_ITER)
          w_state_nxt = S_FIX;
      end
      S_FIX:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_b      <= 32'd0;
      r_opd    <= 32'd0;
      r_is_div <= 1'b0;
      md_done  <= 1'b0;
      hi       <= 32'd0;
      lo       <= 32'd0;
    end else begin
      md_done <= w_fix_write;

      if (w_accept) begin
        r_cnt    <= 5'd0;
        r_acc    <= 32'd0;
        r_is_div <= w_op_div;
        r_b      <= w_op_div ? w_mag_a : w_mag_b;
        r_opd    <= w_op_div ? w_mag_b : w_mag_a;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt + 5'd1;
        if (r_is_div) begin
          r_acc <= w_qbit ? w_ddiff[31:0] : w_dshift[31:0];
          r_b   <= {r_b[30:0], w_qbit};
        end else begin
          r_acc <= w_msum[32:1];
          r_b   <= {w_msum[0], r_b[31:1]};
        end
      end

      if (w_fix_write) begin
        if (r_is_div) begin
          hi <= w_rem;
          lo <= w_quot;
        end else begin
          hi <= w_prod[63:32];
          lo <= w_prod[31:0];
        end
      end else begin
        if (w_mthi)
          hi <= ex_rs_data;
        if (w_mtlo)
          lo <= ex_rs_data;
      end
    end
  end

  assign md_busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_muldiv_unit
// Description : Directed self-checking bench for ex_muldiv_unit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        md_kill;
  logic        md_busy;
  logic        md_done;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  ex_muldiv_unit u_dut (
    .clk        (clk),
    .reset      (reset),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .ex_rs_data (ex_rs_data),
    .ex_rt_data (ex_rt_data),
    .md_kill    (md_kill),
    .md_busy    (md_busy),
    .md_done    (md_done),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  // Present one op for a single cycle; returns on the negedge after its edge.
  task automatic drive_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    ex_valid = 1'b1; ex_op = op; ex_rs_data = a; ex_rt_data = b;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000; ex_rs_data = 32'd0; ex_rt_data = 32'd0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", md_busy); end
    checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", md_done); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_multu_max;
    int n;
    drive_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL multu_busy_cycles: got %0d want 33", n); end
    checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL multu_done: got %b want 1", md_done); end
    checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    @(negedge clk);
    checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL multu_done_width: got %b want 0", md_done); end
  endtask

  task automatic test_mult_signed;
    int n;
    logic [31:0] exp_hi;
`ifdef MULDIV_SIGNED_EN
    exp_hi = 32'hFFFF_FFFF;
`else
    exp_hi = 32'h0000_0006;
`endif
    drive_op(3'b001, 32'hFFFF_FFFD, 32'd7);
    wait_idle(n);
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL mult_hi: got %h want %h", hi, exp_hi); end
    checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
  endtask

  task automatic test_div;
    int n;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;
`ifdef MULDIV_SIGNED_EN
    exp_lo = 32'hFFFF_FFFD; exp_hi = 32'hFFFF_FFFF;
`else
    exp_lo = 32'h7FFF_FFFC; exp_hi = 32'h0000_0001;
`endif
    drive_op(3'b011, 32'hFFFF_FFF9, 32'd2);
    wait_idle(n);
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL div_lo: got %h want %h", lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL div_hi: got %h want %h", hi, exp_hi); end

    drive_op(3'b100, 32'd100, 32'd7);
    wait_idle(n);
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL divu_hi: got %h want 00000002", hi); end

`ifdef MULDIV_SIGNED_EN
    exp_lo = 32'h8000_0000; exp_hi = 32'h0000_0000;
`else
    exp_lo = 32'h0000_0000; exp_hi = 32'h8000_0000;
`endif
    drive_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle(n);
    checks++; if (lo !== exp_lo) begin errors++; $display("FAIL div_min_lo: got %h want %h", lo, exp_lo); end
    checks++; if (hi !== exp_hi) begin errors++; $display("FAIL div_min_hi: got %h want %h", hi, exp_hi); end
  endtask

  task automatic test_div_zero;
    int n;
    drive_op(3'b100, 32'd5, 32'd0);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL divz_busy_cycles: got %0d want 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divz_lo: got %h want ffffffff", lo); end
    checks++; if (hi !== 32'd5) begin errors++; $display("FAIL divz_hi: got %h want 00000005", hi); end
    checks++; if (md_done !== 1'b1) begin errors++; $display("FAIL divz_done: got %b want 1", md_done); end
  endtask

  task automatic test_mt_kill;
    int seen;
    drive_op(3'b101, 32'h1111_1111, 32'd0);
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL mthi_hi: got %h want 11111111", hi); end
    checks++; if (md_busy !== 1'b0 || md_done !== 1'b0) begin errors++; $display("FAIL mthi_flags: got busy %b done %b want 0 0", md_busy, md_done); end
    drive_op(3'b110, 32'h2222_2222, 32'd0);
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL mtlo_lo: got %h want 22222222", lo); end

    drive_op(3'b100, 32'd1000, 32'd3);
    repeat (3) @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b110; ex_rs_data = 32'hAAAA_AAAA;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000; ex_rs_data = 32'd0;
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL busy_mtlo_ignored: got %h want 22222222", lo); end
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL busy_during_run: got %b want 1", md_busy); end
    repeat (3) @(negedge clk);
    md_kill = 1'b1;
    @(negedge clk);
    md_kill = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL kill_run_busy: got %b want 0", md_busy); end
    seen = 0;
    repeat (40) begin
      if (md_done) seen++;
      @(negedge clk);
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL kill_run_done: got %0d pulses want 0", seen); end
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL kill_run_hi: got %h want 11111111", hi); end
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL kill_run_lo: got %h want 22222222", lo); end
  endtask

  task automatic test_kill_idle;
    @(negedge clk);
    ex_valid = 1'b1; ex_op = 3'b010; ex_rs_data = 32'd3; ex_rt_data = 32'd4; md_kill = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000; md_kill = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL kill_idle_start: got busy %b want 0", md_busy); end
    ex_valid = 1'b1; ex_op = 3'b101; ex_rs_data = 32'hDEAD_BEEF; md_kill = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000; ex_rs_data = 32'd0; ex_rt_data = 32'd0; md_kill = 1'b0;
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL kill_idle_mthi: got %h want 11111111", hi); end
    drive_op(3'b111, 32'd9, 32'd9);
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL reserved_op_busy: got %b want 0", md_busy); end
  endtask

  task automatic test_kill_fix;
    drive_op(3'b010, 32'd5, 32'd5);
    repeat (32) @(negedge clk);
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL fix_busy: got %b want 1", md_busy); end
    md_kill = 1'b1;
    @(negedge clk);
    md_kill = 1'b0;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL kill_fix_busy: got %b want 0", md_busy); end
    checks++; if (md_done !== 1'b0) begin errors++; $display("FAIL kill_fix_done: got %b want 0", md_done); end
    checks++; if (lo !== 32'h2222_2222) begin errors++; $display("FAIL kill_fix_lo: got %h want 22222222", lo); end
    checks++; if (hi !== 32'h1111_1111) begin errors++; $display("FAIL kill_fix_hi: got %h want 11111111", hi); end
  endtask

  task automatic test_back_to_back;
    int n;
    drive_op(3'b010, 32'h0001_0000, 32'h0001_0000);
    wait_idle(n);
    checks++; if (hi !== 32'd1 || lo !== 32'd0) begin errors++; $display("FAIL b2b_first: got %h_%h want 00000001_00000000", hi, lo); end
    ex_valid = 1'b1; ex_op = 3'b100; ex_rs_data = 32'd100; ex_rt_data = 32'd7;
    @(negedge clk);
    ex_valid = 1'b0; ex_op = 3'b000; ex_rs_data = 32'd0; ex_rt_data = 32'd0;
    checks++; if (md_busy !== 1'b1) begin errors++; $display("FAIL b2b_accept: got busy %b want 1", md_busy); end
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_busy_cycles: got %0d want 33", n); end
    checks++; if (lo !== 32'd14 || hi !== 32'd2) begin errors++; $display("FAIL b2b_second: got %h_%h want 00000002_0000000e", hi, lo); end
  endtask

  task automatic test_reset_mid;
    int n;
    drive_op(3'b010, 32'h1234_5678, 32'd9);
    repeat (19) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checks++; if (md_busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", md_busy); end
    checks++; if (hi !== 32'd0 || lo !== 32'd0) begin errors++; $display("FAIL rst_mid_hilo: got %h_%h want 0_0", hi, lo); end
    @(negedge clk);
    reset = 1'b0;
    drive_op(3'b010, 32'd3, 32'd4);
    wait_idle(n);
    checks++; if (n !== 33) begin errors++; $display("FAIL post_rst_cycles: got %0d want 33", n); end
    checks++; if (lo !== 32'd12 || hi !== 32'd0) begin errors++; $display("FAIL post_rst_mul: got %h_%h want 00000000_0000000c", hi, lo); end
  endtask

  initial begin
    reset = 1'b1; ex_valid = 1'b0; ex_op = 3'b000;
    ex_rs_data = 32'd0; ex_rt_data = 32'd0; md_kill = 1'b0;
    @(negedge clk);
    test_reset;
    test_multu_max;
    test_mult_signed;
    test_div;
    test_div_zero;
    test_mt_kill;
    test_kill_idle;
    test_kill_fix;
    test_back_to_back;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
